// File: rtl/mnist_pkg.sv
// Shared types and default geometry for the mnist_nn load sequencer.
// Bank order is W1, W2, W3, W4, then X; BANK_LEN follows that order.
package mnist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_COMPUTE,
    S_DONE
  } state_e;

  localparam int NUM_BANKS      = 5;
  localparam int BANK_X         = 4;
  localparam int BANK_IDX_LEN   = 3;
  localparam int W_ADDR_LEN_DEF = 20;
  localparam int X_ADDR_LEN_DEF = 10;

  localparam int BANK_LEN [NUM_BANKS] = '{6, 9, 9, 9, 2};

endpackage

// File: rtl/mnist_addr_gen.sv
// Bank index and word counter across W1..W4 then X; advances once per accepted word.
// Latency: registered, the new bank/count is visible the cycle after an advance.
// Backpressure: none, it only moves when the parent asserts adv.
module mnist_addr_gen
  import mnist_pkg::*;
#(
  parameter int CNT_LEN = W_ADDR_LEN_DEF,
  parameter int W1_LEN  = BANK_LEN[0],
  parameter int W2_LEN  = BANK_LEN[1],
  parameter int W3_LEN  = BANK_LEN[2],
  parameter int W4_LEN  = BANK_LEN[3],
  parameter int X_LEN   = BANK_LEN[4]
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    adv,
  output logic [BANK_IDX_LEN-1:0] bank,
  output logic [CNT_LEN-1:0]      cnt,
  output logic                    last_word
);

  logic [CNT_LEN-1:0] last_idx;

  always_comb begin
    last_idx = '0;
    case (bank)
      3'd0:    last_idx = CNT_LEN'(W1_LEN - 1);
      3'd1:    last_idx = CNT_LEN'(W2_LEN - 1);
      3'd2:    last_idx = CNT_LEN'(W3_LEN - 1);
      3'd3:    last_idx = CNT_LEN'(W4_LEN - 1);
      3'd4:    last_idx = CNT_LEN'(X_LEN - 1);
      default: last_idx = '0;
    endcase
  end

  assign last_word = (cnt == last_idx);

  // No bubble between banks: the word after a bank's last goes to the next bank at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
      cnt  <= '0;
    end else if (clr) begin
      bank <= '0;
      cnt  <= '0;
    end else if (adv) begin
      if (last_word) begin
        cnt  <= '0;
        bank <= (bank == BANK_IDX_LEN'(BANK_X)) ? '0 : bank + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mnist_load_seq.sv
// Streams words into weight banks W1..W4 and input bank X0, then runs one compute pass.
// Latency: accepted word is driven to memory the next cycle; en_compute rises one cycle after the last write.
// Backpressure: in_ready is high only while loading; the stream is stalled in all other states.
module mnist_load_seq
  import mnist_pkg::*;
#(
  parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W1_LEN     = BANK_LEN[0],
  parameter int W2_LEN     = BANK_LEN[1],
  parameter int W3_LEN     = BANK_LEN[2],
  parameter int W4_LEN     = BANK_LEN[3],
  parameter int X_LEN      = BANK_LEN[4],
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic                  in_data,
  output logic                  in_ready,
  output logic                  w_wq,
  output logic [W_SEL_LEN-1:0]  w_sel,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic                  x_wq,
  output logic [X_SEL_LEN-1:0]  x_sel,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic                  wx_write,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_LEN = (W_ADDR_LEN > X_ADDR_LEN) ? W_ADDR_LEN : X_ADDR_LEN;

  state_e                  state, state_d;
  logic                    accept;
  logic                    ag_clr, ag_adv, ag_last;
  logic [BANK_IDX_LEN-1:0] ag_bank;
  logic [CNT_LEN-1:0]      ag_cnt;
  logic [31:0]             tcnt, tcnt_d;

  logic                  w_wq_d, x_wq_d, wx_d, lcc_d, en_d, busy_d, done_d, err_d;
  logic [W_SEL_LEN-1:0]  w_sel_d;
  logic [W_ADDR_LEN-1:0] w_addr_d;
  logic [X_SEL_LEN-1:0]  x_sel_d;
  logic [X_ADDR_LEN-1:0] x_addr_d;

  assign in_ready = (state == S_LOAD_W) || (state == S_LOAD_X);
  assign accept   = in_valid && in_ready;
  assign ag_adv   = accept && !abort;

  mnist_addr_gen #(
    .CNT_LEN (CNT_LEN),
    .W1_LEN  (W1_LEN),
    .W2_LEN  (W2_LEN),
    .W3_LEN  (W3_LEN),
    .W4_LEN  (W4_LEN),
    .X_LEN   (X_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ag_clr),
    .adv       (ag_adv),
    .bank      (ag_bank),
    .cnt       (ag_cnt),
    .last_word (ag_last)
  );

  always_comb begin
    state_d  = state;
    tcnt_d   = tcnt;
    ag_clr   = 1'b0;
    w_wq_d   = 1'b0;
    x_wq_d   = 1'b0;
    w_sel_d  = w_sel;
    w_addr_d = w_addr;
    x_sel_d  = x_sel;
    x_addr_d = x_addr;
    wx_d     = wx_write;
    lcc_d    = load_compute_ctrl;
    en_d     = en_compute;
    busy_d   = busy;
    done_d   = done;
    err_d    = err;

    if (abort) begin
      state_d  = S_IDLE;
      tcnt_d   = '0;
      ag_clr   = 1'b1;
      w_sel_d  = '0;
      w_addr_d = '0;
      x_sel_d  = '0;
      x_addr_d = '0;
      wx_d     = 1'b0;
      lcc_d    = 1'b1;
      en_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD_W;
            ag_clr  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_LOAD_W: begin
          if (accept) begin
            w_wq_d   = 1'b1;
            w_sel_d  = W_SEL_LEN'(ag_bank);
            w_addr_d = W_ADDR_LEN'(ag_cnt);
            wx_d     = in_data;
            if (ag_last && ag_bank == 3'd3) begin
              state_d = S_LOAD_X;
              x_sel_d = '0;
            end
          end
        end
        S_LOAD_X: begin
          if (accept) begin
            x_wq_d   = 1'b1;
            x_sel_d  = '0;
            x_addr_d = X_ADDR_LEN'(ag_cnt);
            wx_d     = in_data;
            if (ag_last) begin
              state_d = S_COMPUTE;
              tcnt_d  = '0;
            end
          end
        end
        S_COMPUTE: begin
          tcnt_d = tcnt + 1'b1;
          // First COMPUTE cycle still carries the final X write, so stay in load mode for it.
          if (!en_compute) begin
            en_d  = 1'b1;
            lcc_d = 1'b0;
          end
          if (en_compute && compute_finish) begin
            state_d = S_DONE;
            en_d    = 1'b0;
            lcc_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (TIMEOUT != 0 && tcnt == 32'(TIMEOUT - 1)) begin
            state_d = S_DONE;
            en_d    = 1'b0;
            lcc_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      tcnt              <= '0;
      w_wq              <= 1'b0;
      w_sel             <= '0;
      w_addr            <= '0;
      x_wq              <= 1'b0;
      x_sel             <= '0;
      x_addr            <= '0;
      wx_write          <= 1'b0;
      load_compute_ctrl <= 1'b1;
      en_compute        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      state             <= state_d;
      tcnt              <= tcnt_d;
      w_wq              <= w_wq_d;
      w_sel             <= w_sel_d;
      w_addr            <= w_addr_d;
      x_wq              <= x_wq_d;
      x_sel             <= x_sel_d;
      x_addr            <= x_addr_d;
      wx_write          <= wx_d;
      load_compute_ctrl <= lcc_d;
      en_compute        <= en_d;
      busy              <= busy_d;
      done              <= done_d;
      err               <= err_d;
    end
  end

endmodule

// File: tb/tb_mnist_load_seq.sv
// Scoreboard bench for mnist_load_seq: the driver pushes expected memory writes, a monitor pops them.
module tb_mnist_load_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid, in_data, compute_finish;
  logic        in_ready, w_wq, x_wq, wx_write, load_compute_ctrl, en_compute, busy, done, err;
  logic [1:0]  w_sel, x_sel;
  logic [19:0] w_addr;
  logic [9:0]  x_addr;

  mnist_load_seq #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .w_wq              (w_wq),
    .w_sel             (w_sel),
    .w_addr            (w_addr),
    .x_wq              (x_wq),
    .x_sel             (x_sel),
    .x_addr            (x_addr),
    .wx_write          (wx_write),
    .load_compute_ctrl (load_compute_ctrl),
    .en_compute        (en_compute),
    .compute_finish    (compute_finish),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_x;
    int sel;
    int addr;
    bit dat;
    int cyc;
  } wr_t;

  localparam int LENS [5] = '{6, 9, 9, 9, 2};

  wr_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  acc;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word n of an inference lands in the bank whose cumulative range contains n.
  function automatic wr_t model(input int n, input bit d, input int c);
    wr_t e;
    int  b   = 0;
    int  off = 0;
    while (b < 4 && n - off >= LENS[b]) begin
      off += LENS[b];
      b++;
    end
    e.is_x = (b == 4);
    e.sel  = e.is_x ? 0 : b;
    e.addr = n - off;
    e.dat  = d;
    e.cyc  = c;
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return {21'd0, in_ready, w_wq, w_sel, w_addr, x_wq, x_sel, x_addr, wx_write,
            load_compute_ctrl, en_compute, busy, done, err};
  endfunction

  function automatic logic [63:0] status();
    return {59'd0, load_compute_ctrl, en_compute, busy, done, err};
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation, in its cycle.
  always @(negedge clk) begin
    logic [63:0] a, e;
    wr_t x;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        x = q.pop_front();
        chk("missing_write", 64'(x.addr), 64'hFFFF_FFFF);
      end
      if (w_wq || x_wq) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {62'd0, w_wq, x_wq}, 64'd0);
        end else begin
          x = q.pop_front();
          a = {8'd0, x_wq, (x_wq ? x_sel : w_sel), (x_wq ? {10'd0, x_addr} : w_addr),
               wx_write, 32'(cyc)};
          e = {8'd0, x.is_x, 2'(x.sel), 20'(x.addr), x.dat, 32'(x.cyc)};
          chk("write", a, e);
        end
      end
    end
  end

  task automatic wait_to(input int t);
    int g = 0;
    while (cyc < t && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) begin
      errors++;
      $display("FAIL wait_to actual=%0d required=%0d", cyc, t);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_start", status(), 64'b10100);
  endtask

  // mode 0: back to back; 1: valid every other cycle; 2: random valid plus stray start pulses.
  task automatic load_words(input int nwords, input int mode, output int last_cyc);
    int  n = 0;
    int  g = 0;
    wr_t e;
    last_cyc = 0;
    while (n < nwords && g < 1000) begin
      @(negedge clk);
      g++;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (g % 2 == 0);
        default: begin
          in_valid = 1'($urandom);
          start    = ($urandom_range(0, 3) == 0);
        end
      endcase
      in_data = 1'($urandom);
      #1;
      if (in_valid && in_ready) begin
        e = model(n, in_data, cyc + 1);
        q.push_back(e);
        last_cyc = cyc + 1;
        n++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (n < nwords) begin
      errors++;
      $display("FAIL load_timeout actual=%0d required=%0d words", n, nwords);
    end
  endtask

  task automatic finish_at(input int a, input int k);
    wait_to(a + k);
    chk("pre_finish", status(), 64'b01100);
    compute_finish = 1'b1;
    @(negedge clk);
    compute_finish = 1'b0;
    chk("finish", status(), 64'b10010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; compute_finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'h10);
    rst_n = 1'b1;

    // Back-to-back load, compute handoff timing, finish 10 cycles into COMPUTE.
    pulse_start();
    load_words(35, 0, acc);
    wait_to(acc);
    chk("compute_c0", status(), 64'b10100);
    wait_to(acc + 1);
    chk("compute_c1", status(), 64'b01100);
    chk("in_ready_compute", {63'd0, in_ready}, 64'd0);
    finish_at(acc, 10);

    // Second start from DONE with gapped stream.
    pulse_start();
    load_words(35, 1, acc);
    finish_at(acc, $urandom_range(2, 12));

    // Timeout with compute_finish held low.
    pulse_start();
    load_words(35, 2, acc);
    wait_to(acc + 15);
    chk("pre_timeout", status(), 64'b01100);
    wait_to(acc + 16);
    chk("timeout", status(), 64'b10011);
    @(negedge clk);
    chk("err_sticky", status(), 64'b10011);

    // Abort after 12 words; start from DONE also clears err.
    pulse_start();
    load_words(12, 2, acc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outs", outs(), 64'h10);

    // Async reset after 20 words.
    pulse_start();
    load_words(20, 0, acc);
    #2 rst_n = 1'b0;
    #1 chk("arst_outs", outs(), 64'h10);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh run must restart at bank 0 addr 0.
    pulse_start();
    load_words(35, 2, acc);
    finish_at(acc, $urandom_range(1, 14));
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
